// File: rtl/mult4_4_ctrl_if.sv
// mult4_4_ctrl_if: handshake and datapath-control bundle between a requester,
// the 4x4 multiply sequencer and its 2x2-partial-product datapath.
interface mult4_4_ctrl_if;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       ready;
    logic       done;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] ans_sel;
    logic       dp_rst;

    modport master (
        output start, a_in, b_in,
        input  ready, done, op_a, op_b, a_sel, b_sel, ans_sel, dp_rst
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, done, op_a, op_b, a_sel, b_sel, ans_sel, dp_rst
    );
endinterface

// File: rtl/mult4_4_ctrl.sv
// mult4_4_ctrl: Moore sequencer driving a 2x2 partial-product datapath through
// clear, four shifted accumulate steps and a one-cycle done pulse.
module mult4_4_ctrl (
    input  logic          clk,
    input  logic          rst,
    mult4_4_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLR, PP0, PP1, PP2, PP3, DONE} state_e;

    state_e     state_q;
    logic [3:0] op_a_q, op_b_q;
    logic       ready_q, done_q, clr_q, a_sel_q, b_sel_q;
    logic [1:0] ans_sel_q;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
            a_sel_q   <= 1'b0;
            b_sel_q   <= 1'b0;
            ans_sel_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= CLR;
                    op_a_q  <= bus.a_in;
                    op_b_q  <= bus.b_in;
                    ready_q <= 1'b0;
                    clr_q   <= 1'b1;
                end
                CLR: begin
                    state_q   <= PP0;
                    clr_q     <= 1'b0;
                    a_sel_q   <= 1'b0;
                    b_sel_q   <= 1'b0;
                    ans_sel_q <= 2'd3;
                end
                PP0: begin
                    state_q   <= PP1;
                    a_sel_q   <= 1'b1;
                    b_sel_q   <= 1'b0;
                    ans_sel_q <= 2'd2;
                end
                PP1: begin
                    state_q   <= PP2;
                    a_sel_q   <= 1'b0;
                    b_sel_q   <= 1'b1;
                    ans_sel_q <= 2'd2;
                end
                PP2: begin
                    state_q   <= PP3;
                    a_sel_q   <= 1'b1;
                    b_sel_q   <= 1'b1;
                    ans_sel_q <= 2'd1;
                end
                PP3: begin
                    state_q   <= DONE;
                    done_q    <= 1'b1;
                    a_sel_q   <= 1'b0;
                    b_sel_q   <= 1'b0;
                    ans_sel_q <= 2'd0;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
    assign bus.a_sel   = a_sel_q;
    assign bus.b_sel   = b_sel_q;
    assign bus.ans_sel = ans_sel_q;
    // Reset also clears the datapath accumulator in the same cycle.
    assign bus.dp_rst  = rst | clr_q;
endmodule

// File: tb/tb_mult4_4_ctrl.sv
// tb_mult4_4_ctrl: drives the sequencer with a behavioural 2x2 datapath attached
// and checks products against plain a*b arithmetic.
module tb_mult4_4_ctrl;
    logic clk, rst;
    mult4_4_ctrl_if bus ();

    mult4_4_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    // Datapath: selected 2-bit slices multiplied, shifted per ans_sel, accumulated.
    logic [7:0] acc;
    logic [1:0] sa, sb;
    logic [7:0] pp;
    always_comb begin
        sa = bus.a_sel ? bus.op_a[3:2] : bus.op_a[1:0];
        sb = bus.b_sel ? bus.op_b[3:2] : bus.op_b[1:0];
        pp = 8'(sa) * 8'(sb);
    end
    always @(posedge clk) begin
        if (bus.dp_rst) acc <= '0;
        else if (bus.ans_sel == 2'd3) acc <= acc + pp;
        else if (bus.ans_sel == 2'd2) acc <= acc + (pp << 2);
        else if (bus.ans_sel == 2'd1) acc <= acc + (pp << 4);
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, output logic [7:0] res, output int lat);
        lat = -1;
        for (int i = 0; i < 20 && !bus.ready; i++) step();
        bus.start = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        res = acc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.ans_sel !== 2'd0 ||
                bus.op_a !== 4'd0 || bus.op_b !== 4'd0 || bus.dp_rst !== 1'b1) begin
                fails++;
                $display("FAIL reset: ready=%b done=%b ans_sel=%0d op_a=%0d op_b=%0d dp_rst=%b, need 1 0 0 0 0 1",
                         bus.ready, bus.done, bus.ans_sel, bus.op_a, bus.op_b, bus.dp_rst);
            end
            if (k == 0) step();
        end
        rst = 1'b0;
        step();
        tests++;
        if (bus.dp_rst !== 1'b0 || bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: dp_rst=%b ready=%b, need 0 1", bus.dp_rst, bus.ready);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_sel [4];
        exp_sel[0] = 4'b0011;
        exp_sel[1] = 4'b1010;
        exp_sel[2] = 4'b0110;
        exp_sel[3] = 4'b1101;
        bus.start = 1'b1;
        bus.a_in = 4'd13;
        bus.b_in = 4'd11;
        step();
        bus.start = 1'b0;
        bus.a_in = 4'd0;
        tests++;
        if (bus.ready !== 1'b0 || bus.dp_rst !== 1'b1 || bus.op_a !== 4'd13 || bus.op_b !== 4'd11) begin
            fails++;
            $display("FAIL single_clr: ready=%b dp_rst=%b op_a=%0d op_b=%0d, need 0 1 13 11",
                     bus.ready, bus.dp_rst, bus.op_a, bus.op_b);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if ({bus.a_sel, bus.b_sel, bus.ans_sel} !== exp_sel[k] || bus.done !== 1'b0 || bus.dp_rst !== 1'b0) begin
                fails++;
                $display("FAIL single_pp%0d: sel=%b done=%b dp_rst=%b, need %b 0 0", k,
                         {bus.a_sel, bus.b_sel, bus.ans_sel}, bus.done, bus.dp_rst, exp_sel[k]);
            end
        end
        step();
        tests++;
        if (bus.done !== 1'b1 || acc !== 8'd143 || bus.ans_sel !== 2'd0) begin
            fails++;
            $display("FAIL single_done: done=%b out=%0d ans_sel=%0d, need 1 143 0", bus.done, acc, bus.ans_sel);
        end
        step();
        tests++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.op_a !== 4'd13) begin
            fails++;
            $display("FAIL single_idle: done=%b ready=%b op_a=%0d, need 0 1 13", bus.done, bus.ready, bus.op_a);
        end
    endtask

    task automatic test_busy_ignore();
        int c0 = done_cnt;
        bus.start = 1'b1;
        bus.a_in = 4'd3;
        bus.b_in = 4'd2;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        bus.a_in = 4'd15;
        step();
        bus.start = 1'b0;
        tests++;
        if (bus.op_a !== 4'd3) begin
            fails++;
            $display("FAIL busy_op_a: op_a=%0d, need 3", bus.op_a);
        end
        step();
        step();
        tests++;
        if (bus.done !== 1'b1 || acc !== 8'd6) begin
            fails++;
            $display("FAIL busy_result: done=%b out=%0d, need 1 6", bus.done, acc);
        end
        for (int i = 0; i < 8; i++) step();
        tests++;
        if (done_cnt - c0 !== 1 || bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL busy_pulses: pulses=%0d ready=%b, need 1 1", done_cnt - c0, bus.ready);
        end
    endtask

    task automatic test_back_to_back();
        int t = 0, t1 = -1, t2 = -1;
        logic [7:0] r1 = 8'hxx, r2 = 8'hxx;
        logic cleared = 1'b0;
        bus.start = 1'b1;
        bus.a_in = 4'd15;
        bus.b_in = 4'd15;
        step();
        bus.a_in = 4'd0;
        bus.b_in = 4'd9;
        for (int i = 0; i < 30 && t2 < 0; i++) begin
            step();
            t++;
            if (t1 >= 0 && bus.dp_rst) cleared = 1'b1;
            if (bus.done && t1 < 0) begin t1 = t; r1 = acc; end
            else if (bus.done) begin t2 = t; r2 = acc; end
        end
        bus.start = 1'b0;
        tests++;
        if (t1 !== 5 || r1 !== 8'd225) begin
            fails++;
            $display("FAIL b2b_first: latency=%0d out=%0d, need 5 225", t1, r1);
        end
        tests++;
        if (t2 - t1 !== 7 || r2 !== 8'd0 || !cleared) begin
            fails++;
            $display("FAIL b2b_second: gap=%0d out=%0d cleared=%b, need 7 0 1", t2 - t1, r2, cleared);
        end
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_abort();
        int c0 = done_cnt;
        logic [7:0] res;
        int lat;
        bus.start = 1'b1;
        bus.a_in = 4'd9;
        bus.b_in = 4'd9;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (bus.ready !== 1'b1 || bus.ans_sel !== 2'd0 || bus.op_a !== 4'd0 || acc !== 8'd0) begin
            fails++;
            $display("FAIL abort_idle: ready=%b ans_sel=%0d op_a=%0d out=%0d, need 1 0 0 0",
                     bus.ready, bus.ans_sel, bus.op_a, acc);
        end
        for (int i = 0; i < 6; i++) step();
        tests++;
        if (done_cnt !== c0) begin
            fails++;
            $display("FAIL abort_nodone: pulses=%0d, need 0", done_cnt - c0);
        end
        run_op(4'd5, 4'd5, res, lat);
        tests++;
        if (res !== 8'd25 || lat !== 5) begin
            fails++;
            $display("FAIL abort_fresh: out=%0d latency=%0d, need 25 5", res, lat);
        end
    endtask

    task automatic test_hold();
        logic [7:0] res;
        int lat;
        int bad = 0;
        run_op(4'd7, 4'd6, res, lat);
        tests++;
        if (res !== 8'd42) begin
            fails++;
            $display("FAIL hold_result: out=%0d, need 42", res);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (acc !== 8'd42 || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d: out=%0d done=%b, need 42 0", i, acc, bus.done);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] res;
        int lat;
        logic [3:0] a, b;
        for (int n = 0; n < 24; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            if (n == 0) begin a = 4'd15; b = 4'd0; end
            run_op(a, b, res, lat);
            tests++;
            if (res !== 8'(a) * 8'(b) || lat !== 5 || bus.op_a !== a || bus.op_b !== b) begin
                fails++;
                $display("FAIL random_%0dx%0d: out=%0d latency=%0d op=%0d,%0d, need %0d 5",
                         a, b, res, lat, bus.op_a, bus.op_b, 8'(a) * 8'(b));
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.a_in = 4'd0;
        bus.b_in = 4'd0;
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
